// File: rtl/fp_mul_iter.sv
// fp_mul_iter -- iterative IEEE-754 single-precision multiplier.
//
// The 24x24 significand product is formed by a shift-add loop that retires
// RADIX_BITS multiplier bits per enabled clock, so a result takes
// NITER+1 = 24/RADIX_BITS + 1 enabled cycles from the start cycle.
// No denormal/NaN/Inf handling: a zero exponent on either operand gives
// z = 0, exponent overflow saturates the exponent field to 8'hFF, and
// exponent underflow gives z = 0.
//
// Parameters:
//   RADIX_BITS  multiplier bits retired per iteration (1, 2, 4 or 8)
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   ce     clock enable; all state holds while low
//   run    operation request, held high until stall falls
//   x, y   operands, sampled only in the start cycle
//   stall  high while run is high and the result is not yet ready
//   z      product, valid once stall falls, stable until the next start
//   ovf    (FPMUL_FLAGS_EN only) current result overflowed
//   unf    (FPMUL_FLAGS_EN only) current result underflowed
//
// Optional feature macro: FPMUL_FLAGS_EN adds the ovf/unf ports.

module fp_mul_iter #(
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        run,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [31:0] z
`ifdef FPMUL_FLAGS_EN
  ,
  output logic        ovf,
  output logic        unf
`endif
);

  localparam int unsigned NITER = 24 / RADIX_BITS;
  localparam int unsigned SW    = $clog2(NITER + 2);
  localparam int unsigned AW    = 24 + RADIX_BITS;

  localparam logic [SW-1:0] S_IDLE = '0;
  localparam logic [SW-1:0] S_LAST = SW'(NITER);
  localparam logic [SW-1:0] S_DONE = SW'(NITER + 1);

  logic [SW-1:0] s, s_next;
  logic [47:0]   p, p_iter;
  logic          sgn;
  logic [7:0]    xe, ye;
  logic [23:0]   yf;

  logic          start, iterate;
  logic [AW-1:0] acc;
  logic [47+RADIX_BITS:0] wide;

  logic [8:0]    e1;
  logic [24:0]   z0;
  logic          zero_in, ovf_c, unf_c;

  assign start   = run && (s == S_IDLE);
  assign iterate = run && (s != S_IDLE) && (s <= S_LAST);
  assign stall   = run && (s != S_DONE);

  // Sequence counter: 0 idle/start, 1..NITER iterating, NITER+1 result ready.
  always_comb begin
    s_next = s;
    if (!run)
      s_next = S_IDLE;
    else if (s != S_DONE)
      s_next = s + SW'(1);
  end

  // One shift-add step: the low RADIX_BITS of P select a multiple of the
  // multiplicand, which is added into the upper half; the sum keeps its
  // carry bits, and the whole {sum, low half} is shifted right. The low
  // half of P starts as the x significand and is consumed from the bottom
  // as product bits arrive at the top.
  always_comb begin
    acc    = {{RADIX_BITS{1'b0}}, p[47:24]}
           + AW'(p[RADIX_BITS-1:0]) * AW'(yf);
    wide   = {acc, p[23:0]};
    p_iter = wide[47+RADIX_BITS:RADIX_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= '0;
      p   <= '0;
      sgn <= 1'b0;
      xe  <= '0;
      ye  <= '0;
      yf  <= '0;
    end else if (ce) begin
      s <= s_next;
      if (start) begin
        sgn <= x[31] ^ y[31];
        xe  <= x[30:23];
        ye  <= y[30:23];
        yf  <= {1'b1, y[22:0]};
        p   <= {24'b0, 1'b1, x[22:0]};
      end else if (iterate) begin
        p <= p_iter;
      end
    end
  end

  // Result formatting is purely combinational from the held state, so z
  // stays put from the end of the iterations until the next start cycle.
  // e1 is evaluated modulo 512: codes 256..383 are overflow, 384..511
  // (including negative exponents) are underflow.
  always_comb begin
    e1      = {1'b0, xe} + {1'b0, ye} - 9'd127 + {8'b0, p[47]};
    z0      = p[47] ? (p[47:23] + 25'd1) : (p[46:22] + 25'd1);
    zero_in = (xe == 8'd0) || (ye == 8'd0);
    ovf_c   = !zero_in && (e1[8:7] == 2'b10);
    unf_c   = !zero_in && (e1[8:7] == 2'b11);
    if (zero_in || unf_c)
      z = '0;
    else if (ovf_c)
      z = {sgn, 8'hFF, z0[23:1]};
    else
      z = {sgn, e1[7:0], z0[23:1]};
  end

`ifdef FPMUL_FLAGS_EN
  assign ovf = ovf_c;
  assign unf = unf_c;
`endif

endmodule

// File: tb/tb_fp_mul_iter.sv
// tb_fp_mul_iter -- self-checking bench for fp_mul_iter.
// Runs a radix-2 (RADIX_BITS=1) and a radix-16 (RADIX_BITS=4) instance side
// by side on shared stimulus and compares latency and results with a
// reference model built on a plain 64-bit significand multiply.
// Works with or without FPMUL_FLAGS_EN defined.

module tb_fp_mul_iter;

  logic        clk = 1'b0;
  logic        rst, ce, run;
  logic [31:0] x, y;
  logic        stall1, stall4;
  logic [31:0] z1, z4;
`ifdef FPMUL_FLAGS_EN
  logic        ovf1, unf1, ovf4, unf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_mul_iter #(.RADIX_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .run(run), .x(x), .y(y),
    .stall(stall1), .z(z1)
`ifdef FPMUL_FLAGS_EN
    , .ovf(ovf1), .unf(unf1)
`endif
  );

  fp_mul_iter #(.RADIX_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce), .run(run), .x(x), .y(y),
    .stall(stall4), .z(z4)
`ifdef FPMUL_FLAGS_EN
    , .ovf(ovf4), .unf(unf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact significand product, round by adding one at the bit
  // below the kept fraction, exponent rules applied on integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          output bit ov, output bit un);
    logic [63:0] ma, mb, p, z0;
    logic [22:0] frac;
    logic        sg;
    int          e;
    ma   = 64'(a[22:0]) | 64'h80_0000;
    mb   = 64'(b[22:0]) | 64'h80_0000;
    p    = ma * mb;
    e    = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(p[47]);
    z0   = (p[47] ? (p >> 23) : (p >> 22)) + 64'd1;
    frac = z0[23:1];
    sg   = a[31] ^ b[31];
    ov   = 1'b0;
    un   = 1'b0;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'd0;
    // 9-bit exponent wraps: 384 and above read as negative, i.e. underflow
    if (e < 0 || e >= 384) begin
      un = 1'b1;
      return 32'd0;
    end
    if (e > 255) begin
      ov = 1'b1;
      return {sg, 8'hFF, frac};
    end
    return {sg, e[7:0], frac};
  endfunction

  // One operation on both instances. pause_at: hold ce low for 5 cycles
  // once the radix-2 stall count reaches this value; rst_at: pulse reset at
  // that count and expect a clean restart. -1 disables either.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int pause_at, input int rst_at);
    logic [31:0] ez;
    bit          ov, un, done, did_rst;
    int          c1, c4;
    ez = ref_mul(a, b, ov, un);
    @(negedge clk);
    x = a; y = b; run = 1'b1;
    c1 = 0; c4 = 0; done = 1'b0; did_rst = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      #1;
      if (stall1) c1++;
      if (stall4) c4++;
      if (!stall1 && !stall4) begin
        done = 1'b1;
      end else begin
        if (i == 1) begin
          x = $urandom;
          y = $urandom;
        end
        if (c1 == pause_at) ce = 1'b0;
        if (c1 == pause_at + 5) ce = 1'b1;
        if (c1 == rst_at && !did_rst) begin
          did_rst = 1'b1;
          rst = 1'b1;
          #1;
          chk("rst_z1", z1, 32'd0);
          chk("rst_z4", z4, 32'd0);
          chk("rst_stall", {30'd0, stall1, stall4}, 32'd3);
          x = a; y = b;
          rst = 1'b0;
          c1 = 1; c4 = 1;
        end
        @(negedge clk);
      end
    end
    chk("timeout", {31'd0, done}, 32'd1);
    chk("lat1", 32'(c1), 32'(25 + ((pause_at > 0) ? 5 : 0)));
    chk("lat4", 32'(c4), 32'd7);
    chk("z1", z1, ez);
    chk("z4", z4, ez);
`ifdef FPMUL_FLAGS_EN
    chk("flags1", {30'd0, ovf1, unf1}, {30'd0, ov, un});
    chk("flags4", {30'd0, ovf4, unf4}, {30'd0, ov, un});
`endif
    @(negedge clk);
    run = 1'b0;
    #1;
    chk("stall_idle", {30'd0, stall1, stall4}, 32'd0);
    @(negedge clk);
    #1;
    chk("z1_hold", z1, ez);
    chk("z4_hold", z4, ez);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; run = 1'b0; x = '0; y = '0;
    #12;
    chk("reset_z1", z1, 32'd0);
    chk("reset_z4", z4, 32'd0);
    chk("reset_stall_lo", {30'd0, stall1, stall4}, 32'd0);
    run = 1'b1;
    #1;
    chk("reset_stall_hi", {30'd0, stall1, stall4}, 32'd3);
`ifdef FPMUL_FLAGS_EN
    chk("reset_flags", {28'd0, ovf1, unf1, ovf4, unf4}, 32'd0);
`endif
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_op(32'h3F80_0000, 32'h3F80_0000, -1, -1);
    run_op(32'h3FC0_0000, 32'h3FC0_0000, -1, -1);
    run_op(32'hC000_0000, 32'h4040_0000, -1, -1);
    run_op(32'h0000_0000, 32'h4049_0FDB, -1, -1);
    run_op(32'h7F00_0000, 32'h7F00_0000, -1, -1);
    run_op(32'h0080_0000, 32'h0080_0000, -1, -1);

    // clock-enable freeze mid-operation, then reset mid-operation
    run_op(32'h3F80_0001, 32'h4049_0FDB, 11, -1);
    run_op(32'hBFB3_3333, 32'h42F6_E979, -1, 11);

    // abort: drop run partway, then a fresh operation must restart cleanly
    @(negedge clk);
    x = 32'h4120_0000; y = 32'h4120_0000; run = 1'b1;
    repeat (5) @(negedge clk);
    run = 1'b0;
    run_op(32'h4049_0FDB, 32'hC02D_F854, -1, -1);

    for (int k = 0; k < 16; k++)
      run_op($urandom, $urandom, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
